apr_ifetch_seq: RTL

- Instruction-fetch and decode sequencer for the APR.
- Requests each instruction word from core memory over a request/acknowledge handshake and loads the left half into the IR.
- Holds the IR stable while the combinational decoder settles, then issues one dispatch pulse to execute logic.
- Maintains the 18-bit PC, including skip, jump and wrap-around.

---
 rtl/apr_ifetch_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/apr_ifetch_seq.sv
// APR instruction fetch/decode sequencer: fetches a word, holds the IR for
// DECODE_WAIT cycles, pulses decode_go, then waits for exec_done.
// Optional macro APR_SINGLE_INST_EN adds input cont and single-steps.
// Ports: clk, reset (async, active-low), start/stop/pc_load/pc_in control,
// mem_rq/mem_addr/mem_ack/mem_data memory, ir/ir_y/ir_uuo/ir_iot decode,
// decode_go/exec_done/exec_skip/exec_jump/jump_addr execute, pc, run.
module apr_ifetch_seq #(
    parameter int unsigned DECODE_WAIT = 2,
    parameter logic [17:0] PC_RESET    = 18'o000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
`ifdef APR_SINGLE_INST_EN
    input  logic        cont,
`endif
    input  logic        pc_load,
    input  logic [17:0] pc_in,
    output logic        mem_rq,
    output logic [17:0] mem_addr,
    input  logic        mem_ack,
    input  logic [0:35] mem_data,
    output logic [0:17] ir,
    output logic [0:17] ir_y,
    output logic        ir_uuo,
    output logic        ir_iot,
    output logic        decode_go,
    input  logic        exec_done,
    input  logic        exec_skip,
    input  logic        exec_jump,
    input  logic [17:0] jump_addr,
    output logic [17:0] pc,
    output logic        run
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_EXEC
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] pc_q, pc_d;
    logic        stop_q, stop_d;
    logic [3:0]  cnt_q;
    logic [0:17] ir_q, iry_q;
    logic        uuo_q, iot_q;
    logic        rq_q, go_q, run_q;
    logic        resume;
    logic        halt;
    logic        ir_ld;

`ifdef APR_SINGLE_INST_EN
    assign resume = start | cont;
    assign halt   = 1'b1;
`else
    assign resume = start;
    assign halt   = stop_q | stop;
`endif

    assign ir_ld = (state_q == S_FETCH) & mem_ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stop_d  = stop_q;
        unique case (state_q)
            S_IDLE: begin
                if (pc_load) pc_d = pc_in;
                if (resume) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    pc_d    = pc_q + 18'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cnt_q <= 4'd1) state_d = S_DISPATCH;
            end
            S_DISPATCH: state_d = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    if (exec_jump)
                        pc_d = jump_addr;
                    else if (exec_skip)
                        pc_d = pc_q + 18'd1;
                    state_d = halt ? S_IDLE : S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // stop is remembered until the machine next parks in IDLE
        if (state_q != S_IDLE && stop) stop_d = 1'b1;
        if (state_d == S_IDLE) stop_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            stop_q  <= 1'b0;
            cnt_q   <= 4'd0;
            ir_q    <= '0;
            iry_q   <= '0;
            uuo_q   <= 1'b0;
            iot_q   <= 1'b0;
            rq_q    <= 1'b0;
            go_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stop_q  <= stop_d;
            if (ir_ld) begin
                ir_q  <= mem_data[0:17];
                iry_q <= mem_data[18:35];
                uuo_q <= (mem_data[0:2] == 3'b000);
                iot_q <= (mem_data[0:2] == 3'b111);
                cnt_q <= 4'(DECODE_WAIT);
            end else if (state_q == S_DECODE) begin
                cnt_q <= cnt_q - 4'd1;
            end
            // outputs registered from the next state so they align with it
            rq_q  <= (state_d == S_FETCH);
            go_q  <= (state_d == S_DISPATCH);
            run_q <= (state_d != S_IDLE);
        end
    end

    assign mem_rq    = rq_q;
    assign mem_addr  = pc_q;
    assign ir        = ir_q;
    assign ir_y      = iry_q;
    assign ir_uuo    = uuo_q;
    assign ir_iot    = iot_q;
    assign decode_go = go_q;
    assign pc        = pc_q;
    assign run       = run_q;

endmodule
